// File: rtl/speech256_pkg.sv
// Shared widths, frame payload and controller state encoding for the SOURCE
// excitation interface.
package speech256_pkg;

    localparam int unsigned PERIOD_W = 8;
    localparam int unsigned AMP_W    = 15;
    localparam int unsigned DUR_W    = 8;

    typedef struct packed {
        logic [PERIOD_W-1:0]     period;
        logic signed [AMP_W-1:0] amp;
        logic [DUR_W-1:0]        dur;
    } frame_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_WAIT_EDGE = 2'd2
    } state_t;

endpackage

// File: rtl/source_frame_fifo.sv
// Synchronous show-ahead frame FIFO; rd_data always presents the head entry.
module source_frame_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/source_ctrl.sv
// SOURCE initiator: sample-strobe divider, frame FIFO and pitch-synchronous
// frame sequencer driving period/amplitude.
module source_ctrl
    import speech256_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [PERIOD_W-1:0]     wr_period,
    input  logic signed [AMP_W-1:0] wr_amp,
    input  logic [DUR_W-1:0]        wr_dur,
    input  logic                    period_done,
    output logic                    strobe,
    output logic [PERIOD_W-1:0]     period,
    output logic signed [AMP_W-1:0] amplitude,
    output logic                    busy,
    output logic                    underrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FRM_W = $bits(frame_t);
    localparam logic [PERIOD_W-1:0] EDGE_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

    logic [DIV_W-1:0]        div_cnt;
    state_t                  state;
    state_t                  state_n;
    logic [PERIOD_W-1:0]     period_n;
    logic signed [AMP_W-1:0] amp_n;
    logic [DUR_W-1:0]        dur_cnt;
    logic [DUR_W-1:0]        dur_n;
    logic [PERIOD_W-1:0]     edge_cnt;
    logic [PERIOD_W-1:0]     edge_n;
    logic                    underrun_n;
    logic                    pop_c;
    logic                    advance_c;
    logic                    wr_accept_c;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [FRM_W-1:0]        rd_data;
    frame_t                  wr_frame;
    frame_t                  rd_frame;

    assign wr_frame    = '{period: wr_period, amp: wr_amp, dur: wr_dur};
    assign rd_frame    = frame_t'(rd_data);
    assign wr_ready    = !fifo_full;
    assign wr_accept_c = wr_valid && !fifo_full && !flush;
    assign busy        = (state != ST_IDLE) || (fifo_count != '0);

    source_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRM_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .wr_en   (wr_accept_c),
        .wr_data (FRM_W'(wr_frame)),
        .rd_en   (pop_c),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Free-running divider; strobe is registered so it lines up with div_cnt==CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            strobe  <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
            strobe  <= (div_cnt == DIV_W'(CLK_DIV - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            period    <= '0;
            amplitude <= '0;
            dur_cnt   <= '0;
            edge_cnt  <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            period    <= period_n;
            amplitude <= amp_n;
            dur_cnt   <= dur_n;
            edge_cnt  <= edge_n;
            underrun  <= underrun_n;
        end
    end

    always_comb begin
        state_n    = state;
        period_n   = period;
        amp_n      = amplitude;
        dur_n      = dur_cnt;
        edge_n     = edge_cnt;
        underrun_n = 1'b0;
        pop_c      = 1'b0;
        advance_c  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (strobe && !fifo_empty) pop_c = 1'b1;
            end
            ST_PLAY: begin
                if (strobe) begin
                    dur_n = dur_cnt - DUR_W'(1);
                    if (dur_cnt == DUR_W'(1)) begin
                        if (period == '0) begin
                            advance_c = 1'b1;
                        end else begin
                            state_n = ST_WAIT_EDGE;
                            edge_n  = '0;
                        end
                    end
                end
            end
            ST_WAIT_EDGE: begin
                if (period_done) begin
                    advance_c = 1'b1;
                end else if (strobe) begin
                    if (edge_cnt == EDGE_LAST) advance_c = 1'b1;
                    else                       edge_n = edge_cnt + PERIOD_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Frame boundary: chain straight into the next frame or fall silent.
        if (advance_c) begin
            if (!fifo_empty) begin
                pop_c = 1'b1;
            end else begin
                state_n    = ST_IDLE;
                period_n   = '0;
                amp_n      = '0;
                underrun_n = 1'b1;
            end
        end

        if (pop_c) begin
            state_n  = ST_PLAY;
            period_n = rd_frame.period;
            amp_n    = rd_frame.amp;
            dur_n    = (rd_frame.dur == '0) ? DUR_W'(1) : rd_frame.dur;
        end

        if (flush) begin
            state_n    = ST_IDLE;
            period_n   = '0;
            amp_n      = '0;
            dur_n      = '0;
            edge_n     = '0;
            underrun_n = 1'b0;
            pop_c      = 1'b0;
        end
    end

endmodule

// File: tb/tb_source_ctrl.sv
// Directed bench for source_ctrl: frame table plus hand-written multi-cycle
// sequences (backpressure, same-strobe period_done, timeout, flush).
module tb_source_ctrl;

    localparam int unsigned CLK_DIV = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_period;
    logic [14:0] wr_amp;
    logic [7:0]  wr_dur;
    logic        period_done;
    logic        strobe;
    logic [7:0]  period;
    logic [14:0] amplitude;
    logic        busy;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  period;
        logic [14:0] amp;
        logic [7:0]  dur;
        int          strobes;
        bit          voiced;
    } vec_t;

    vec_t vecs[5];

    source_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_period   (wr_period),
        .wr_amp      (wr_amp),
        .wr_dur      (wr_dur),
        .period_done (period_done),
        .strobe      (strobe),
        .period      (period),
        .amplitude   (amplitude),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at the falling edge where strobe is high.
    task automatic wait_strobe();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * CLK_DIV && !seen; i++) begin
            @(negedge clk);
            seen = strobe;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL strobe_timeout: got no strobe expected strobe");
        end
    endtask

    task automatic write_frame(input logic [7:0] p, input logic [14:0] a, input logic [7:0] d);
        bit acc = 1'b0;
        wr_period = p;
        wr_amp    = a;
        wr_dur    = d;
        wr_valid  = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = wr_ready;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL write_timeout: got wr_ready=0 expected accept");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{period: 8'd50,  amp: 15'd15000,  dur: 8'd20, strobes: 20, voiced: 1'b1};
        vecs[1] = '{period: 8'd0,   amp: 15'd8000,   dur: 8'd3,  strobes: 3,  voiced: 1'b0};
        vecs[2] = '{period: 8'd100, amp: 15'h7FFB,   dur: 8'd0,  strobes: 1,  voiced: 1'b1};
        vecs[3] = '{period: 8'd1,   amp: 15'd16383,  dur: 8'd1,  strobes: 1,  voiced: 1'b1};
        vecs[4] = '{period: 8'd0,   amp: 15'h4000,   dur: 8'd0,  strobes: 1,  voiced: 1'b0};

        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; period_done = 1'b0;
        wr_period = '0; wr_amp = '0; wr_dur = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_strobe", 32'(strobe), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_amp", 32'(amplitude), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("first_strobe", 32'(strobe), (k == 4 || k == 9) ? 1 : 0);
        end

        // Frame table: one frame at a time from idle.
        for (int v = 0; v < 5; v++) begin
            wait_strobe();
            write_frame(vecs[v].period, vecs[v].amp, vecs[v].dur);
            wait_strobe();
            @(negedge clk);
            chk("load_period", 32'(period), 32'(vecs[v].period));
            chk("load_amp", 32'(amplitude), 32'(vecs[v].amp));
            chk("load_busy", 32'(busy), 1);
            for (int s = 0; s < vecs[v].strobes; s++) wait_strobe();
            chk("play_hold_period", 32'(period), 32'(vecs[v].period));
            @(negedge clk);
            if (vecs[v].voiced) begin
                chk("wait_period", 32'(period), 32'(vecs[v].period));
                chk("wait_underrun", 32'(underrun), 0);
                wait_strobe();
                @(negedge clk);
                chk("wait_still_amp", 32'(amplitude), 32'(vecs[v].amp));
                period_done = 1'b1;
                @(negedge clk);
                period_done = 1'b0;
            end
            chk("end_underrun", 32'(underrun), 1);
            chk("end_period", 32'(period), 0);
            chk("end_amp", 32'(amplitude), 0);
            chk("end_busy", 32'(busy), 0);
            @(negedge clk);
            chk("underrun_pulse", 32'(underrun), 0);
        end

        // Five back-to-back writes into a 4-deep FIFO; playback order by amplitude.
        wait_strobe();
        for (int f = 0; f < 4; f++) write_frame(8'd0, 15'(101 + f), 8'd2);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("full_busy", 32'(busy), 1);
        write_frame(8'd0, 15'd105, 8'd2);
        chk("order_amp_0", 32'(amplitude), 101);
        for (int j = 1; j < 5; j++) begin
            wait_strobe();
            wait_strobe();
            @(negedge clk);
            chk("order_amp", 32'(amplitude), 32'(101 + j));
            chk("order_no_underrun", 32'(underrun), 0);
        end
        wait_strobe();
        wait_strobe();
        @(negedge clk);
        chk("order_end_underrun", 32'(underrun), 1);
        chk("order_end_amp", 32'(amplitude), 0);

        // period_done in PLAY is ignored, also on the expiry strobe; then chain to a queued frame.
        wait_strobe();
        write_frame(8'd40, 15'd3000, 8'd2);
        write_frame(8'd0, 15'd777, 8'd1);
        wait_strobe();
        @(negedge clk);
        chk("pd_load_period", 32'(period), 40);
        period_done = 1'b1;
        @(negedge clk);
        period_done = 1'b0;
        chk("pd_play_ignored", 32'(period), 40);
        wait_strobe();
        wait_strobe();
        period_done = 1'b1;
        @(negedge clk);
        period_done = 1'b0;
        chk("pd_same_strobe_hold", 32'(period), 40);
        chk("pd_same_strobe_underrun", 32'(underrun), 0);
        wait_strobe();
        @(negedge clk);
        chk("pd_wait_hold", 32'(amplitude), 3000);
        period_done = 1'b1;
        @(negedge clk);
        period_done = 1'b0;
        chk("chain_period", 32'(period), 0);
        chk("chain_amp", 32'(amplitude), 777);
        chk("chain_no_underrun", 32'(underrun), 0);
        wait_strobe();
        @(negedge clk);
        chk("chain_end_underrun", 32'(underrun), 1);

        // Timeout: period_done never arrives.
        wait_strobe();
        write_frame(8'd50, 15'd1000, 8'd1);
        wait_strobe();
        @(negedge clk);
        chk("to_load", 32'(period), 50);
        wait_strobe();
        repeat (254) wait_strobe();
        @(negedge clk);
        chk("to_hold_254", 32'(period), 50);
        chk("to_no_underrun_254", 32'(underrun), 0);
        wait_strobe();
        @(negedge clk);
        chk("to_underrun_255", 32'(underrun), 1);
        chk("to_period_255", 32'(period), 0);

        // Flush mid-PLAY with two frames queued; a write in the flush cycle is dropped.
        wait_strobe();
        write_frame(8'd60, 15'd2000, 8'd10);
        write_frame(8'd70, 15'd2100, 8'd10);
        write_frame(8'd80, 15'd2200, 8'd10);
        wait_strobe();
        @(negedge clk);
        chk("fl_load", 32'(period), 60);
        wait_strobe();
        wait_strobe();
        flush = 1'b1;
        wr_valid = 1'b1; wr_period = 8'd90; wr_amp = 15'd2300; wr_dur = 8'd4;
        @(negedge clk);
        flush = 1'b0;
        wr_valid = 1'b0;
        chk("fl_period", 32'(period), 0);
        chk("fl_amp", 32'(amplitude), 0);
        chk("fl_busy", 32'(busy), 0);
        chk("fl_underrun", 32'(underrun), 0);
        chk("fl_wr_ready", 32'(wr_ready), 1);
        wait_strobe();
        wait_strobe();
        @(negedge clk);
        chk("fl_stays_silent", 32'(period), 0);
        chk("fl_stays_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
